// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared constants for the external interrupt controller
// Purpose: register address map, line count and default synchronizer depth.
// Ports: none (package). Optional feature macro used by intc: INTC_IPI_EN.
package intc_pkg;
    localparam int INTC_LINES       = 8;   // matches CSR HWI_in width
    localparam int INTC_SYNC_STAGES = 2;

    localparam logic [3:0] INTC_PEND = 4'h0;
    localparam logic [3:0] INTC_EN   = 4'h4;
    localparam logic [3:0] INTC_EDGE = 4'h8;
    localparam logic [3:0] INTC_IPI  = 4'hC;
endpackage

// File: rtl/intc_sync.sv
// rtl/intc_sync.sv - one-line synchronizer with rising-edge detect
// Purpose: SYNC_STAGES-deep synchronizer for one async line plus a prev flop.
// Ports: clk, rst (sync active-high), i_async (raw line),
//        o_s (synchronized level), o_rise (s high this cycle, low the last).
module intc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_s,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_chain[SYNC_STAGES-1];
    assign o_rise = o_s & ~r_prev;
endmodule

// File: rtl/intc.sv
// rtl/intc.sv - external interrupt controller feeding CSR ESTAT.HWI/IPI
// Purpose: synchronizes 8 device lines, applies level/edge mode and enable,
//          registers HWI_out; optional software IPI flag when INTC_IPI_EN is defined.
// Ports: clk, rst (sync active-high), irq_src[7:0] (async lines),
//        req/we/addr[3:0]/wdata[31:0] (single-cycle MMIO request),
//        rdata[31:0]/ack (response one cycle after req),
//        HWI_out[7:0] (to CSR HWI_in), IPI_out (to CSR IPI_in).
module intc
    import intc_pkg::*;
#(
    parameter int SYNC_STAGES = INTC_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INTC_LINES-1:0] irq_src,
    input  logic                  req,
    input  logic                  we,
    input  logic [3:0]            addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ack,
    output logic [INTC_LINES-1:0] HWI_out,
    output logic                  IPI_out
);
    logic [INTC_LINES-1:0] w_s;
    logic [INTC_LINES-1:0] w_rise;
    logic [INTC_LINES-1:0] r_pend;
    logic [INTC_LINES-1:0] r_en;
    logic [INTC_LINES-1:0] r_edge;
    logic [INTC_LINES-1:0] r_hwi;
    logic                  r_ack;
    logic [31:0]           r_rdata;
    logic [31:0]           w_rdata;
    logic [3:0]            w_reg;
    logic                  w_wr_pend;
    logic                  w_wr_en;
    logic                  w_wr_edge;
    logic [INTC_LINES-1:0] w_clr;
    logic [INTC_LINES-1:0] w_mode_chg;
    logic [INTC_LINES-1:0] w_pend_next;
    logic                  w_unused_bits;
    logic                  r_ipi;

    for (genvar i = 0; i < INTC_LINES; i++) begin : g_sync
        intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .i_async(irq_src[i]),
            .o_s    (w_s[i]),
            .o_rise (w_rise[i])
        );
    end

    assign w_reg      = {addr[3:2], 2'b00};
    assign w_wr_pend  = req & we & (w_reg == INTC_PEND);
    assign w_wr_en    = req & we & (w_reg == INTC_EN);
    assign w_wr_edge  = req & we & (w_reg == INTC_EDGE);

    // W1C only reaches edge-mode bits; level bits just follow the source.
    assign w_clr      = w_wr_pend ? (wdata[INTC_LINES-1:0] & r_edge) : '0;
    // A mode switch discards whatever was latched under the old mode.
    assign w_mode_chg = w_wr_edge ? (wdata[INTC_LINES-1:0] ^ r_edge) : '0;
    // New rise is OR-ed after the clear so a colliding W1C cannot lose it.
    assign w_pend_next = ((r_edge & ((r_pend & ~w_clr) | w_rise)) | (~r_edge & w_s))
                         & ~w_mode_chg;

    assign w_unused_bits = ^{addr[1:0], wdata[31:INTC_LINES]};

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            INTC_PEND: w_rdata[INTC_LINES-1:0] = r_pend;
            INTC_EN:   w_rdata[INTC_LINES-1:0] = r_en;
            INTC_EDGE: w_rdata[INTC_LINES-1:0] = r_edge;
`ifdef INTC_IPI_EN
            INTC_IPI:  w_rdata[0] = r_ipi;
`endif
            default:   w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_en    <= '0;
            r_edge  <= '0;
            r_hwi   <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_pend  <= w_pend_next;
            r_hwi   <= r_pend & r_en;
            r_ack   <= req;
            r_rdata <= (req & ~we) ? w_rdata : '0;
            if (w_wr_en)   r_en   <= wdata[INTC_LINES-1:0];
            if (w_wr_edge) r_edge <= wdata[INTC_LINES-1:0];
        end
    end

`ifdef INTC_IPI_EN
    logic r_ipi_out;
    logic w_wr_ipi;

    assign w_wr_ipi = req & we & (w_reg == INTC_IPI);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ipi     <= 1'b0;
            r_ipi_out <= 1'b0;
        end else begin
            r_ipi_out <= r_ipi;
            // Set is checked first so a set+clear write leaves the flag set.
            if (w_wr_ipi && wdata[0])      r_ipi <= 1'b1;
            else if (w_wr_ipi && wdata[1]) r_ipi <= 1'b0;
        end
    end

    assign IPI_out = r_ipi_out;
`else
    assign r_ipi   = 1'b0;
    assign IPI_out = 1'b0;
`endif

    assign HWI_out = r_hwi;
    assign ack     = r_ack;
    assign rdata   = r_rdata;
endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - directed self-checking bench for intc
module tb_intc;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic [7:0]  HWI_out;
    logic        IPI_out;

    int total = 0;
    int bad   = 0;

    intc dut (
        .clk    (clk),
        .rst    (rst),
        .irq_src(irq_src),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ack    (ack),
        .HWI_out(HWI_out),
        .IPI_out(IPI_out)
    );

    always #5 clk = ~clk;

    // Called just after a negedge; returns just after the next negedge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic k);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        d = rdata; k = ack;
        req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; irq_src = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (HWI_out !== 8'h00) begin bad++; $display("FAIL reset_hwi got=%h exp=00", HWI_out); end
        total++; if (IPI_out !== 1'b0) begin bad++; $display("FAIL reset_ipi got=%b exp=0", IPI_out); end
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    endtask

    task automatic test_level;
        logic [31:0] d; logic k;
        bus_write(4'h4, 32'hFF);
        @(negedge clk);
        irq_src = 8'h05;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            total++;
            if (HWI_out !== ((e == 4) ? 8'h05 : 8'h00)) begin
                bad++; $display("FAIL level_rise edge=%0d got=%h exp=%h", e, HWI_out, (e == 4) ? 8'h05 : 8'h00);
            end
        end
        bus_write(4'h0, 32'hFF);
        bus_read(4'h0, d, k);
        total++; if (d !== 32'h05) begin bad++; $display("FAIL level_w1c_noeffect got=%h exp=05", d); end
        irq_src = 8'h00;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            total++;
            if (HWI_out !== ((e == 4) ? 8'h00 : 8'h05)) begin
                bad++; $display("FAIL level_fall edge=%0d got=%h exp=%h", e, HWI_out, (e == 4) ? 8'h00 : 8'h05);
            end
        end
    endtask

    task automatic test_edge_w1c;
        logic [31:0] d; logic k;
        bus_write(4'h8, 32'h01);
        bus_write(4'h4, 32'h01);
        irq_src = 8'h01;
        @(negedge clk);
        irq_src = 8'h00;
        repeat (5) @(negedge clk);
        total++; if (HWI_out !== 8'h01) begin bad++; $display("FAIL edge_latch got=%h exp=01", HWI_out); end
        repeat (3) @(negedge clk);
        total++; if (HWI_out !== 8'h01) begin bad++; $display("FAIL edge_hold got=%h exp=01", HWI_out); end
        bus_read(4'h0, d, k);
        total++; if (d !== 32'h01 || k !== 1'b1) begin bad++; $display("FAIL edge_pend_read got=%h ack=%b exp=01 ack=1", d, k); end
        bus_write(4'h0, 32'h01);
        total++; if (HWI_out !== 8'h01) begin bad++; $display("FAIL w1c_edge1 got=%h exp=01", HWI_out); end
        @(negedge clk);
        total++; if (HWI_out !== 8'h00) begin bad++; $display("FAIL w1c_edge2 got=%h exp=00", HWI_out); end
    endtask

    task automatic test_w1c_collide;
        logic [31:0] d; logic k;
        irq_src = 8'h01;
        @(negedge clk);
        irq_src = 8'h00;
        @(negedge clk);
        bus_write(4'h0, 32'h01);   // sampled at the edge the rise lands in pend
        bus_read(4'h0, d, k);
        total++; if (d !== 32'h01) begin bad++; $display("FAIL collide_pend got=%h exp=01", d); end
        bus_write(4'h0, 32'h01);
        bus_read(4'h0, d, k);
        total++; if (d !== 32'h00) begin bad++; $display("FAIL collide_clear got=%h exp=00", d); end
    endtask

    task automatic test_disabled_line;
        logic [31:0] d; logic k;
        bus_write(4'h4, 32'h00);
        bus_write(4'h8, 32'h09);
        irq_src = 8'h08;
        @(negedge clk);
        irq_src = 8'h00;
        repeat (5) @(negedge clk);
        total++; if (HWI_out !== 8'h00) begin bad++; $display("FAIL disabled_hwi got=%h exp=00", HWI_out); end
        bus_read(4'h0, d, k);
        total++; if (d !== 32'h08) begin bad++; $display("FAIL disabled_pend got=%h exp=08", d); end
        bus_write(4'h4, 32'h08);
        total++; if (HWI_out !== 8'h00) begin bad++; $display("FAIL enable_edge1 got=%h exp=00", HWI_out); end
        @(negedge clk);
        total++; if (HWI_out !== 8'h08) begin bad++; $display("FAIL enable_edge2 got=%h exp=08", HWI_out); end
        bus_write(4'h8, 32'h01);
        bus_read(4'h0, d, k);
        total++; if (d !== 32'h00) begin bad++; $display("FAIL modechg_clear got=%h exp=00", d); end
        repeat (2) @(negedge clk);
        total++; if (HWI_out !== 8'h00) begin bad++; $display("FAIL modechg_hwi got=%h exp=00", HWI_out); end
    endtask

    task automatic test_back_to_back;
        req = 1'b1; we = 1'b1; addr = 4'h4; wdata = 32'hA5;
        @(negedge clk);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%b exp=1", ack); end
        we = 1'b0; addr = 4'h4; wdata = '0;
        @(negedge clk);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got=%b exp=1", ack); end
        total++; if (rdata !== 32'h000000A5) begin bad++; $display("FAIL b2b_rd_en got=%h exp=000000a5", rdata); end
        addr = 4'hC;
        @(negedge clk);
        req = 1'b0;
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL b2b_ack3 got=%b exp=1", ack); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL b2b_rd_unmapped got=%h exp=0", rdata); end
        @(negedge clk);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_end got=%b exp=0", ack); end
    endtask

    task automatic test_ipi;
        logic [31:0] d; logic k;
`ifdef INTC_IPI_EN
        bus_write(4'hC, 32'h3);
        @(negedge clk);
        total++; if (IPI_out !== 1'b1) begin bad++; $display("FAIL ipi_set got=%b exp=1", IPI_out); end
        bus_read(4'hC, d, k);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL ipi_read got=%h exp=1", d); end
        bus_write(4'hC, 32'h2);
        total++; if (IPI_out !== 1'b1) begin bad++; $display("FAIL ipi_clr1 got=%b exp=1", IPI_out); end
        @(negedge clk);
        total++; if (IPI_out !== 1'b0) begin bad++; $display("FAIL ipi_clr2 got=%b exp=0", IPI_out); end
`else
        bus_write(4'hC, 32'h3);
        repeat (2) @(negedge clk);
        total++; if (IPI_out !== 1'b0) begin bad++; $display("FAIL ipi_off got=%b exp=0", IPI_out); end
        bus_read(4'hC, d, k);
        total++; if (d !== 32'h0 || k !== 1'b1) begin bad++; $display("FAIL ipi_off_read got=%h ack=%b exp=0 ack=1", d, k); end
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic k;
        bus_write(4'h8, 32'h00);
        bus_write(4'h4, 32'hFF);
        irq_src = 8'h05;
        repeat (6) @(negedge clk);
        total++; if (HWI_out !== 8'h05) begin bad++; $display("FAIL mid_pre got=%h exp=05", HWI_out); end
        irq_src = 8'h00;
        req = 1'b1; we = 1'b0; addr = 4'h4; rst = 1'b1;
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL mid_ack got=%b exp=0", ack); end
        total++; if (HWI_out !== 8'h00) begin bad++; $display("FAIL mid_hwi got=%h exp=00", HWI_out); end
        bus_read(4'h4, d, k);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_en got=%h exp=0", d); end
    endtask

    initial begin
        test_reset;
        test_level;
        test_edge_w1c;
        test_w1c_collide;
        test_disabled_line;
        test_back_to_back;
        test_ipi;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
